// File: rtl/ex_stage_divhilo_if.sv
// Decode-to-execute, execute-to-memory/decode and data SRAM signal group
// for the MIPS execute stage. The master side is whatever surrounds the
// stage (decode, stall controller, memory stage, SRAM); the slave side is
// the execute stage itself.
interface ex_stage_divhilo_if #(
  parameter int ID_TO_EX_WD  = 163,
  parameter int EX_TO_MEM_WD = 80
);
  logic [5:0]              stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [37:0]             ex_to_id;
  logic                    ex_is_load;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    output stall,
    output id_to_ex_bus,
    input  ex_to_mem_bus,
    input  ex_to_id,
    input  ex_is_load,
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    input  stallreq_for_ex
  );

  modport slave (
    input  stall,
    input  id_to_ex_bus,
    output ex_to_mem_bus,
    output ex_to_id,
    output ex_is_load,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    output stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage_divhilo.sv
// MIPS execute stage: input pipeline register, ALU, data SRAM request,
// forwarding to decode, HI/LO registers and a restoring divider that
// produces one quotient bit per cycle while holding the front of the pipe.
module ex_stage_divhilo #(
  parameter int ID_TO_EX_WD  = 163,
  parameter int EX_TO_MEM_WD = 80,
  parameter int DIV_STEPS    = 32
) (
  input logic               clk,
  input logic               rst,
  ex_stage_divhilo_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Two's-complement sign correction used for operand magnitudes and results.
  function automatic logic [31:0] sign_fix(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

  // ---------------- stage p0: decode-to-execute register ----------------
  logic [ID_TO_EX_WD-1:0] bus_p0;
  logic                   load_or_bubble;

  // A held EX (stall[2]) with a running MEM (stall[3]=0) inserts a bubble.
  assign load_or_bubble = ~(bus.stall[2] & bus.stall[3]);

  // Input register: bubble, load or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_p0 <= '0;
    end else if (bus.stall[2] && !bus.stall[3]) begin
      bus_p0 <= '0;
    end else if (!bus.stall[2]) begin
      bus_p0 <= bus.id_to_ex_bus;
    end
  end

  logic [3:0]  readen;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign readen     = bus_p0[162:159];
  assign pc         = bus_p0[158:127];
  assign inst       = bus_p0[126:95];
  assign alu_op     = bus_p0[94:83];
  assign src1_sel   = bus_p0[82:80];
  assign src2_sel   = bus_p0[79:76];
  assign ram_en     = bus_p0[75];
  assign ram_wen    = bus_p0[74:71];
  assign rf_we      = bus_p0[70];
  assign rf_waddr   = bus_p0[69:65];
  assign sel_rf_res = bus_p0[64];
  assign rs_val     = bus_p0[63:32];
  assign rt_val     = bus_p0[31:0];

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_special;
  logic       is_mfhi;
  logic       is_mflo;
  logic       is_div;
  logic       is_signed_div;

  assign opcode        = inst[31:26];
  assign funct         = inst[5:0];
  assign is_special    = (opcode == 6'h00);
  assign is_mfhi       = is_special && (funct == 6'h10);
  assign is_mflo       = is_special && (funct == 6'h12);
  assign is_signed_div = is_special && (funct == 6'h1A);
  assign is_div        = is_signed_div || (is_special && (funct == 6'h1B));

  // Operand selection; an all-zero select yields zero.
  logic signed [31:0] src1_val;
  logic signed [31:0] src2_val;
  logic        [4:0]  sa;

  always_comb begin
    src1_val = '0;
    if (src1_sel[0])      src1_val = rs_val;
    else if (src1_sel[1]) src1_val = pc;
    else if (src1_sel[2]) src1_val = {27'b0, inst[10:6]};
  end

  always_comb begin
    src2_val = '0;
    if (src2_sel[0])      src2_val = rt_val;
    else if (src2_sel[1]) src2_val = {{16{inst[15]}}, inst[15:0]};
    else if (src2_sel[2]) src2_val = 32'd8;
    else if (src2_sel[3]) src2_val = {16'b0, inst[15:0]};
  end

  assign sa = src1_val[4:0];

  // ALU: alu_op is one-hot, MSB = add down to LSB = lui.
  logic signed [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    if (alu_op[11])      alu_res = src1_val + src2_val;
    else if (alu_op[10]) alu_res = src1_val - src2_val;
    else if (alu_op[9])  alu_res = {31'b0, (src1_val < src2_val)};
    else if (alu_op[8])  alu_res = {31'b0, ($unsigned(src1_val) < $unsigned(src2_val))};
    else if (alu_op[7])  alu_res = src1_val & src2_val;
    else if (alu_op[6])  alu_res = ~(src1_val | src2_val);
    else if (alu_op[5])  alu_res = src1_val | src2_val;
    else if (alu_op[4])  alu_res = src1_val ^ src2_val;
    else if (alu_op[3])  alu_res = src2_val << sa;
    else if (alu_op[2])  alu_res = $unsigned(src2_val) >> sa;
    else if (alu_op[1])  alu_res = src2_val >>> sa;
    else if (alu_op[0])  alu_res = src2_val << 16;
  end

  // ---------------- divider control ----------------
  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             div_done;
  logic             div_start;
  logic             div_step;
  logic             div_finish;
  logic             stallreq;

  // Divider state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and stall request; a finished divide held in EX must not rerun.
  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    div_start  = 1'b0;
    div_step   = 1'b0;
    div_finish = 1'b0;
    case (state)
      IDLE: begin
        if (is_div && !div_done) begin
          stallreq   = 1'b1;
          div_start  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        stallreq = 1'b1;
        div_step = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        div_finish = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Step counter and completion flag; any load or bubble of the input
  // register means a new instruction, so the completion flag is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_done <= 1'b0;
    end else begin
      if (div_start)     cnt <= '0;
      else if (div_step) cnt <= cnt + CNT_W'(1);
      if (load_or_bubble)  div_done <= 1'b0;
      else if (div_finish) div_done <= 1'b1;
    end
  end

  // ---------------- divider datapath ----------------
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_den;
  logic        quo_neg;
  logic        rem_neg;
  logic [32:0] div_tmp;
  logic        div_ge;
  logic [31:0] rem_nxt;

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign div_tmp = {div_rem, div_quo[31]};
  assign div_ge  = (div_tmp >= {1'b0, div_den});
  assign rem_nxt = div_ge ? 32'(div_tmp - {1'b0, div_den}) : div_tmp[31:0];

  // Operand magnitudes latched at start, then one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_rem <= '0;
      div_quo <= sign_fix(is_signed_div & rs_val[31], rs_val);
      div_den <= sign_fix(is_signed_div & rt_val[31], rt_val);
      quo_neg <= is_signed_div & (rs_val[31] ^ rt_val[31]);
      rem_neg <= is_signed_div & rs_val[31];
    end else if (div_step) begin
      div_rem <= rem_nxt;
      div_quo <= {div_quo[30:0], div_ge};
    end
  end

  logic [31:0] hi;
  logic [31:0] lo;

  // HI/LO written once per divide; a zero divisor leaves all-ones in LO
  // and the dividend (already the restored remainder) in HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_finish) begin
      hi <= sign_fix(rem_neg, div_rem);
      lo <= (div_den == '0) ? '1 : sign_fix(quo_neg, div_quo);
    end
  end

  // ---------------- outputs ----------------
  logic [31:0] ex_result;

  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign bus.ex_to_mem_bus   = EX_TO_MEM_WD'({pc, ram_en, ram_wen, readen, sel_rf_res,
                                              rf_we, rf_waddr, ex_result});
  assign bus.ex_to_id        = {rf_we, rf_waddr, ex_result};
  assign bus.ex_is_load      = ram_en & (|readen);
  assign bus.data_sram_en    = ram_en;
  assign bus.data_sram_wen   = ram_wen;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = rt_val;
  assign bus.stallreq_for_ex = stallreq;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], bus.stall[5:4], bus.stall[1:0]};

endmodule

// File: tb/tb_ex_stage_divhilo.sv
// Directed bench for the execute stage: ALU, load/store request, bubble,
// divider latency, signed/zero-divisor corner cases, hold and reset.
module tb_ex_stage_divhilo;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ext_stall;
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  ex_stage_divhilo_if bus_if ();

  // Stall controller model: a busy divider freezes IF/ID/EX, bubbles MEM.
  assign bus_if.stall = bus_if.stallreq_for_ex ? 6'b001111 : ext_stall;

  ex_stage_divhilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_OR = 12'h020, OP_SRA = 12'h002,
                          OP_LUI = 12'h001;
  localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
  localparam logic [3:0]  S2_RT = 4'b0001, S2_SIMM = 4'b0010, S2_8 = 4'b0100,
                          S2_ZIMM = 4'b1000;

  function automatic logic [162:0] mk(
    input logic [3:0] readen, input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
    input logic ram_en, input logic [3:0] wen, input logic we, input logic [4:0] wa,
    input logic sel, input logic [31:0] rs, input logic [31:0] rt);
    return {readen, pc, inst, op, s1, s2, ram_en, wen, we, wa, sel, rs, rt};
  endfunction

  function automatic logic [162:0] dv(input logic sgn, input logic [31:0] rs,
                                      input logic [31:0] rt);
    return mk(4'h0, 32'hBFC00100, {6'h00, 5'd1, 5'd2, 10'd0, (sgn ? 6'h1A : 6'h1B)},
              12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
  endfunction

  function automatic logic [162:0] mfx(input logic lo_sel);
    return mk(4'h0, 32'hBFC00200, {6'h00, 10'd0, 5'd3, 5'd0, (lo_sel ? 6'h12 : 6'h10)},
              12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [162:0] b);
    bus_if.id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  // Called while a fresh divide sits in EX; counts stall cycles up to DONE.
  task automatic wait_div(input string tag);
    int n = 0;
    while (bus_if.stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk(tag, 80'(n), 80'd33);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    ext_stall = 6'b0;
    bus_if.id_to_ex_bus = mk(4'h0, 32'hBFC00000, {6'h09, 5'd1, 5'd2, 16'hFFFF}, OP_ADD,
                             S1_RS, S2_SIMM, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_bus", bus_if.ex_to_mem_bus, 80'd0);
    chk("rst_ex_to_id", bus_if.ex_to_id, 80'd0);
    chk("rst_stallreq", bus_if.stallreq_for_ex, 80'd0);
    chk("rst_sram_en", bus_if.data_sram_en, 80'd0);
    rst = 1'b0;

    // ALU
    @(posedge clk);
    #1;
    chk("addiu_ex_to_id", bus_if.ex_to_id, 80'({1'b1, 5'd2, 32'd4}));
    issue(mk(4'h0, 32'hBFC00004, {6'h0F, 5'd0, 5'd3, 16'h1234}, OP_LUI, 3'b0, S2_ZIMM,
             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0));
    chk("lui", bus_if.ex_to_id[31:0], 80'h12340000);
    issue(mk(4'h0, 32'hBFC00008, {6'h0D, 5'd1, 5'd4, 16'h000F}, OP_OR, S1_RS, S2_ZIMM,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0F0, 32'd0));
    chk("ori", bus_if.ex_to_id[31:0], 80'hFF);
    issue(mk(4'h0, 32'hBFC0000C, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23}, OP_SUB, S1_RS,
             S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd3, 32'd5));
    chk("subu", bus_if.ex_to_id[31:0], 80'hFFFFFFFE);
    issue(mk(4'h0, 32'hBFC00010, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, OP_SLT, S1_RS,
             S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFFFFFF, 32'd1));
    chk("slt", bus_if.ex_to_id[31:0], 80'd1);
    issue(mk(4'h0, 32'hBFC00014, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B}, OP_SLTU, S1_RS,
             S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFFFFFF, 32'd1));
    chk("sltu", bus_if.ex_to_id[31:0], 80'd0);
    issue(mk(4'h0, 32'hBFC00018, {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, OP_SRA, S1_SA,
             S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'h80000000));
    chk("sra", bus_if.ex_to_id[31:0], 80'hF8000000);
    issue(mk(4'h0, 32'hBFC00010, {6'h03, 26'h0}, OP_ADD, S1_PC, S2_8,
             1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0));
    chk("jal_link", bus_if.ex_to_id, 80'({1'b1, 5'd31, 32'hBFC00018}));

    // Store then load
    issue(mk(4'h0, 32'hBFC0001C, {6'h2B, 5'd5, 5'd6, 16'h0004}, OP_ADD, S1_RS, S2_SIMM,
             1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h200, 32'hDEADBEEF));
    chk("sw_addr", bus_if.data_sram_addr, 80'h204);
    chk("sw_wdata", bus_if.data_sram_wdata, 80'hDEADBEEF);
    chk("sw_wen", bus_if.data_sram_wen, 80'hF);
    chk("sw_is_load", bus_if.ex_is_load, 80'd0);
    issue(mk(4'hF, 32'hBFC00020, {6'h23, 5'd5, 5'd6, 16'h0008}, OP_ADD, S1_RS, S2_SIMM,
             1'b1, 4'h0, 1'b1, 5'd6, 1'b1, 32'h100, 32'd0));
    chk("lw_en", bus_if.data_sram_en, 80'd1);
    chk("lw_addr", bus_if.data_sram_addr, 80'h108);
    chk("lw_wen", bus_if.data_sram_wen, 80'd0);
    chk("lw_is_load", bus_if.ex_is_load, 80'd1);
    chk("lw_mem_bus", bus_if.ex_to_mem_bus,
        {32'hBFC00020, 1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 5'd6, 32'h108});

    // Bubble
    ext_stall = 6'b000100;
    @(posedge clk);
    #1;
    chk("bubble_mem_bus", bus_if.ex_to_mem_bus, 80'd0);
    chk("bubble_sram_en", bus_if.data_sram_en, 80'd0);
    chk("bubble_is_load", bus_if.ex_is_load, 80'd0);
    ext_stall = 6'b0;

    // divu 100/7; mflo enters EX right after DONE
    issue(dv(1'b0, 32'd100, 32'd7));
    bus_if.id_to_ex_bus = mfx(1'b1);
    wait_div("divu_stall");
    @(posedge clk);
    #1;
    chk("divu_lo", bus_if.ex_to_id[31:0], 80'd14);
    issue(mfx(1'b0));
    chk("divu_hi", bus_if.ex_to_id[31:0], 80'd2);

    // div -7/2
    issue(dv(1'b1, 32'hFFFFFFF9, 32'd2));
    bus_if.id_to_ex_bus = mfx(1'b1);
    wait_div("div_neg_stall");
    @(posedge clk);
    #1;
    chk("div_neg_lo", bus_if.ex_to_id[31:0], 80'hFFFFFFFD);
    issue(mfx(1'b0));
    chk("div_neg_hi", bus_if.ex_to_id[31:0], 80'hFFFFFFFF);

    // div 0x80000000 / -1
    issue(dv(1'b1, 32'h80000000, 32'hFFFFFFFF));
    bus_if.id_to_ex_bus = mfx(1'b1);
    wait_div("div_ovf_stall");
    @(posedge clk);
    #1;
    chk("div_ovf_lo", bus_if.ex_to_id[31:0], 80'h80000000);
    issue(mfx(1'b0));
    chk("div_ovf_hi", bus_if.ex_to_id[31:0], 80'd0);

    // div 9/0
    issue(dv(1'b1, 32'd9, 32'd0));
    bus_if.id_to_ex_bus = mfx(1'b1);
    wait_div("div0_stall");
    @(posedge clk);
    #1;
    chk("div0_lo", bus_if.ex_to_id[31:0], 80'hFFFFFFFF);
    issue(mfx(1'b0));
    chk("div0_hi", bus_if.ex_to_id[31:0], 80'd9);

    // Back-to-back: divu 100/7 followed directly by divu 50/8
    issue(dv(1'b0, 32'd100, 32'd7));
    bus_if.id_to_ex_bus = dv(1'b0, 32'd50, 32'd8);
    wait_div("b2b_first_stall");
    @(posedge clk);
    #1;
    bus_if.id_to_ex_bus = mfx(1'b1);
    wait_div("b2b_second_stall");
    @(posedge clk);
    #1;
    chk("b2b_lo", bus_if.ex_to_id[31:0], 80'd6);
    issue(mfx(1'b0));
    chk("b2b_hi", bus_if.ex_to_id[31:0], 80'd2);

    // Divide finishes while EX is held externally for 5 more cycles
    issue(dv(1'b0, 32'd1003, 32'd10));
    ext_stall = 6'b001111;
    wait_div("hold_stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_no_restart", bus_if.stallreq_for_ex, 80'd0);
    end
    bus_if.id_to_ex_bus = mfx(1'b1);
    ext_stall = 6'b0;
    @(posedge clk);
    #1;
    chk("hold_lo", bus_if.ex_to_id[31:0], 80'd100);
    issue(mfx(1'b0));
    chk("hold_hi", bus_if.ex_to_id[31:0], 80'd3);

    // Reset at RUN cycle 10
    issue(dv(1'b0, 32'd100, 32'd7));
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("run_before_rst", bus_if.stallreq_for_ex, 80'd1);
    rst = 1'b1;
    #1;
    chk("rst_run_stallreq", bus_if.stallreq_for_ex, 80'd0);
    chk("rst_run_mem_bus", bus_if.ex_to_mem_bus, 80'd0);
    bus_if.id_to_ex_bus = mfx(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_lo", bus_if.ex_to_id[31:0], 80'd0);
    chk("rst_no_div", bus_if.stallreq_for_ex, 80'd0);
    issue(mfx(1'b0));
    chk("rst_hi", bus_if.ex_to_id[31:0], 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
